// File: rtl/nibble_serial_add_ctrl_if.sv
// ----------------------------------------------------------------------------
// nibble_serial_add_ctrl_if
//
// Purpose: bundles the request/result signals of nibble_serial_add_ctrl so a
// requester (ALU front end, accumulator) and the sequencer share one port.
//
// Signals:
//   start    requester -> adder  request, sampled only while ready=1
//   a, b     requester -> adder  WIDTH-bit operands, captured on acceptance
//   c_in     requester -> adder  carry-in, captured on acceptance
//   sub      requester -> adder  subtract select (only with NIBBLE_ADD_SUB_EN)
//   ready    adder -> requester  idle, a start will be accepted
//   busy     adder -> requester  nibble steps in progress
//   done     adder -> requester  one-cycle pulse, result just updated
//   sum      adder -> requester  registered result
//   c_out    adder -> requester  registered carry out of the MSB
//   overflow adder -> requester  registered signed overflow
//
// Modports: master (requester side), slave (adder side).
// Optional feature macro: NIBBLE_ADD_SUB_EN adds the sub signal.
// ----------------------------------------------------------------------------
interface nibble_serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 16
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
`ifdef NIBBLE_ADD_SUB_EN
    logic             sub;
`endif
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;

    modport master (
`ifdef NIBBLE_ADD_SUB_EN
        output sub,
`endif
        output start,
        output a,
        output b,
        output c_in,
        input  ready,
        input  busy,
        input  done,
        input  sum,
        input  c_out,
        input  overflow
    );

    modport slave (
`ifdef NIBBLE_ADD_SUB_EN
        input  sub,
`endif
        input  start,
        input  a,
        input  b,
        input  c_in,
        output ready,
        output busy,
        output done,
        output sum,
        output c_out,
        output overflow
    );

endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// ----------------------------------------------------------------------------
// nibble_serial_add_ctrl
//
// Purpose: adds two WIDTH-bit operands on a single 4-bit ripple-carry slice,
// one nibble per clock, with the inter-nibble carry held in a register.
// Trades latency (NIB+2 cycles per operation) for a narrow adder.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; discards any operation in flight
//   bus    nibble_serial_add_ctrl_if.slave
//            start/a/b/c_in(/sub) in, ready/busy/done/sum/c_out/overflow out
//
// Parameters:
//   WIDTH  operand/result width, a multiple of 4 and at least 8
//
// Optional feature macro: NIBBLE_ADD_SUB_EN
//   When defined, bus.sub=1 at acceptance computes a-b by loading ~b and a
//   forced carry-in of 1 (c_in ignored); c_out=1 then means "no borrow".
//
// Timing (start accepted at edge E0): nibble j stored at E(j+1); sum, c_out
// and overflow update at E(NIB); done is high for the cycle after E(NIB);
// ready returns at E(NIB+1).
// ----------------------------------------------------------------------------
module nibble_serial_add_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    nibble_serial_add_ctrl_if.slave   bus
);

    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned KW  = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [KW-1:0] KLast = KW'(NIB - 1);

    // FSM encoding
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    // Operand registers shift right one nibble per step so the slice always
    // reads bits [3:0]; no variable part-selects are needed.
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    // Result builds from the top down: each step shifts right and inserts the
    // new nibble at the MSB, leaving it aligned after NIB steps.
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;

    // ------------------------------------------------------------------------
    // 4-bit ripple-carry slice
    // ------------------------------------------------------------------------
    logic [3:0] slice_s;
    logic [4:0] slice_c;

    always_comb begin
        slice_s    = '0;
        slice_c    = '0;
        slice_c[0] = carry_q;
        for (int i = 0; i < 4; i++) begin
            slice_s[i]   = a_q[i] ^ b_q[i] ^ slice_c[i];
            slice_c[i+1] = (a_q[i] & b_q[i]) | (slice_c[i] & (a_q[i] ^ b_q[i]));
        end
    end

    // ------------------------------------------------------------------------
    // Operand capture (optionally inverting B for subtraction)
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

`ifdef NIBBLE_ADD_SUB_EN
    always_comb begin
        if (bus.sub) begin
            b_load     = ~bus.b;
            carry_load = 1'b1;
        end else begin
            b_load     = bus.b;
            carry_load = bus.c_in;
        end
    end
`else
    always_comb begin
        b_load     = bus.b;
        carry_load = bus.c_in;
    end
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        k_d     = k_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = b_load;
                    carry_d = carry_load;
                    k_d     = '0;
                    state_d = StRun;
                end
            end

            StRun: begin
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                res_d   = {slice_s, res_q[WIDTH-1:4]};
                carry_d = slice_c[4];
                if (k_q == KLast) begin
                    // Final nibble: publish the whole result at once. k holds
                    // rather than wrapping.
                    sum_d   = res_d;
                    c_out_d = slice_c[4];
                    // Carry into bit WIDTH-1 is the slice's bit-3 carry.
                    ovf_d   = slice_c[3] ^ slice_c[4];
                    state_d = StDone;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: status decoded straight from state so reset acts immediately
    // ------------------------------------------------------------------------
    assign bus.ready    = (state_q == StIdle);
    assign bus.busy     = (state_q == StRun);
    assign bus.done     = (state_q == StDone);
    assign bus.sum      = sum_q;
    assign bus.c_out    = c_out_q;
    assign bus.overflow = ovf_q;

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Multi-cycle sequencer that adds two WIDTH-bit operands on one shared 4-bit ripple-carry slice (the team's FourBitFullAdder), one nibble per clock.
- Carry between nibbles is held in a register.
- Provides a start/ready/done handshake.
- Sits between a requesting datapath (ALU front end, accumulator) and the narrow adder slice, trading latency for area.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and >= 8.
- NIB (localparam), WIDTH/4, number of nibble steps.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only while ready=1
- a  input  WIDTH  operand A, captured on acceptance
- b  input  WIDTH  operand B, captured on acceptance
- c_in  input  1  carry-in, captured on acceptance
- ready  output  1  high in IDLE; block can accept start
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse: result valid and newly updated
- sum  output  WIDTH  registered result; held until next completion
- c_out  output  1  registered carry out of MSB nibble
- overflow  output  1  registered signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, ready=1, busy=0, done=0.
  - sum=0, c_out=0, overflow=0.
  - Internal operand/shift registers, carry register and nibble counter all cleared.
  - Applies immediately, including mid-operation; the operation in flight is discarded with no done pulse.
- FSM states: IDLE, RUN, DONE.
  - IDLE: ready=1. On an edge with start=1:
    - latch a, b, c_in into the operand registers and the carry register;
    - clear the nibble counter k;
    - go to RUN.
  - RUN: busy=1. Each cycle:
    - the slice adds a_reg[4k+3:4k] + b_reg[4k+3:4k] + carry_reg;
    - at the edge, the 4-bit result is written into result_reg[4k+3:4k], carry_reg takes the slice carry, and k increments;
    - at the edge where k=NIB-1 is processed, the final carry goes to c_out and result_reg is copied to sum;
    - overflow = (carry into bit WIDTH-1) XOR (final carry);
    - go to DONE.
  - DONE: done=1 for exactly one cycle. The next edge unconditionally returns to IDLE.
- Latency (start accepted at edge E0):
  - Nibble j is stored at edge E(j+1).
  - sum, c_out and overflow update at E(NIB); done is high in the cycle after E(NIB).
  - ready returns at E(NIB+1).
  - Back-to-back throughput: one operation per NIB+2 cycles.
- Boundary rules:
  - start while not IDLE is ignored and not queued.
  - Changes on a, b, c_in after acceptance have no effect.
  - sum is never partially updated; outputs change only at the completion edge.
  - Carry out of the MSB nibble is not wrapped into the next operation. c_in is re-latched every request.
  - k counts 0..NIB-1. It never wraps in RUN because the FSM exits at NIB-1.

Optional Feature:
- Macro: NIBBLE_ADD_SUB_EN
- Defined:
  - Extra input port sub (1 bit), captured with the operands on acceptance.
  - When sub=1: b_reg is loaded as ~b, carry_reg is loaded as 1, c_in is ignored, result is a-b.
  - c_out=1 means no borrow.
  - overflow uses the same MSB carry-in XOR carry-out rule.
  - When sub=0: identical to the addition behaviour.
- Undefined: port sub is absent; addition only.

Test Plan (WIDTH=16, NIB=4):
1. a=0x1234, b=0x4321, c_in=0, start pulse at E0 -> busy high E0..E4; sum=0x5555, c_out=0, overflow=0 valid at E4; done high only in the cycle after E4; ready=1 after E5.
2. a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1, overflow=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, c_out=0, overflow=1.
3. start held high continuously with a=0x0001, b=0x0001, c_in=1 -> accepted at E0, E6, E12; sum=0x0003 each time; exactly one done pulse per operation. Operands changed mid-RUN do not alter the result.
4. Start 0xAAAA+0x5555. Drive rst_n low asynchronously after 2 nibbles are stored -> ready=1, busy=0, done=0, sum=0, c_out=0 without waiting for a clock edge. After release, a new start computes 0x0F0F+0x00F1=0x1000 correctly.
5. Start issued during the DONE cycle -> ignored: no second done pulse, and sum is unchanged until a start is accepted in IDLE.
6. (NIBBLE_ADD_SUB_EN) sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, c_out=0. Then sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, c_out=1, overflow=1.
